// File: rtl/fetch_decode.sv
// Fetch/decode sequencer: fetches one instruction byte per request and decodes it for one EXEC cycle.
// pc advances (or jumps to r0 on a taken condition) at the end of EXEC.
module fetch_decode (
    input  logic       clk,
    input  logic       reset,
    output logic       instr_req,
    output logic [7:0] pc,
    input  logic [7:0] instr_in,
    input  logic       instr_valid,
    input  logic [7:0] r0_in,
    input  logic [7:0] r3_in,
    output logic [2:0] src_a,
    output logic [2:0] src_b,
    output logic [2:0] dst,
    output logic       write_enable,
    output logic [1:0] wb_sel,
    output logic [7:0] imm_out,
    output logic [2:0] alu_op
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;

    state_e     state_q;
    logic [7:0] pc_q;
    logic [7:0] ir_q;
    logic       cond_met;
    logic       we_dec;

    // r3 is treated as signed: bit 7 is the sign.
    always_comb begin
        cond_met = 1'b0;
        case (ir_q[2:0])
            3'b000:  cond_met = 1'b0;
            3'b001:  cond_met = (r3_in == 8'h00);
            3'b010:  cond_met = r3_in[7];
            3'b011:  cond_met = r3_in[7] || (r3_in == 8'h00);
            3'b100:  cond_met = 1'b1;
            3'b101:  cond_met = (r3_in != 8'h00);
            3'b110:  cond_met = !r3_in[7];
            default: cond_met = !r3_in[7] && (r3_in != 8'h00);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
        end else begin
            case (state_q)
                StIdle: state_q <= StFetch;
                StFetch: begin
                    if (instr_valid) begin
                        ir_q    <= instr_in;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (ir_q[7:6] == 2'b11 && cond_met) pc_q <= r0_in;
                    else                                pc_q <= pc_q + 8'd1;
                    state_q <= StFetch;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        src_a   = 3'd0;
        src_b   = 3'd0;
        dst     = 3'd0;
        alu_op  = 3'd0;
        wb_sel  = 2'b00;
        imm_out = 8'h00;
        we_dec  = 1'b0;
        if (state_q == StExec) begin
            case (ir_q[7:6])
                2'b00: begin
                    imm_out = {2'b00, ir_q[5:0]};
                    we_dec  = 1'b1;
                end
                2'b01: begin
                    src_a  = 3'd1;
                    src_b  = 3'd2;
                    dst    = 3'd3;
                    alu_op = ir_q[2:0];
                    wb_sel = 2'b01;
                    we_dec = 1'b1;
                end
                2'b10: begin
                    src_a  = ir_q[5:3];
                    dst    = ir_q[2:0];
                    wb_sel = 2'b10;
                    we_dec = 1'b1;
                end
                default: we_dec = 1'b0;
            endcase
        end
    end

    // Reset during EXEC aborts the write on the very edge that would commit it.
    assign write_enable = we_dec && !reset;
    assign instr_req    = (state_q == StFetch);
    assign pc           = pc_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: expected decode/next-pc is pushed when an instruction is
// presented and popped when the DUT reaches EXEC.
module tb_fetch_decode;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_req;
    logic [7:0] pc;
    logic [7:0] instr_in;
    logic       instr_valid;
    logic [7:0] r0_in;
    logic [7:0] r3_in;
    logic [2:0] src_a, src_b, dst, alu_op;
    logic       write_enable;
    logic [1:0] wb_sel;
    logic [7:0] imm_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_pc;

    typedef struct packed {
        logic [2:0] src_a;
        logic [2:0] src_b;
        logic [2:0] dst;
        logic [2:0] alu_op;
        logic [1:0] wb_sel;
        logic [7:0] imm;
        logic       we;
        logic [7:0] next_pc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_decode dut (
        .clk          (clk),
        .reset        (reset),
        .instr_req    (instr_req),
        .pc           (pc),
        .instr_in     (instr_in),
        .instr_valid  (instr_valid),
        .r0_in        (r0_in),
        .r3_in        (r3_in),
        .src_a        (src_a),
        .src_b        (src_b),
        .dst          (dst),
        .write_enable (write_enable),
        .wb_sel       (wb_sel),
        .imm_out      (imm_out),
        .alu_op       (alu_op)
    );

    function automatic exp_t model(input logic [7:0] i, input logic [7:0] r0,
                                   input logic [7:0] r3, input logic [7:0] cur_pc);
        exp_t e;
        int   v;
        bit   taken;
        e     = '0;
        taken = 1'b0;
        v     = int'($signed(r3));
        case (i[7:6])
            2'b00: begin e.imm = {2'b00, i[5:0]}; e.we = 1'b1; end
            2'b01: begin
                e.src_a = 3'd1; e.src_b = 3'd2; e.dst = 3'd3;
                e.alu_op = i[2:0]; e.wb_sel = 2'b01; e.we = 1'b1;
            end
            2'b10: begin e.src_a = i[5:3]; e.dst = i[2:0]; e.wb_sel = 2'b10; e.we = 1'b1; end
            default: begin
                case (i[2:0])
                    3'd0: taken = 0;
                    3'd1: taken = (v == 0);
                    3'd2: taken = (v < 0);
                    3'd3: taken = (v <= 0);
                    3'd4: taken = 1;
                    3'd5: taken = (v != 0);
                    3'd6: taken = (v >= 0);
                    default: taken = (v > 0);
                endcase
            end
        endcase
        e.next_pc = taken ? r0 : 8'((cur_pc + 1) % 256);
        return e;
    endfunction

    task automatic wait_fetch();
        int n = 0;
        while (instr_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_req !== 1'b1) begin
            errors++;
            $display("FAIL wait_fetch: instr_req=%b required 1 within 20 cycles", instr_req);
        end
    endtask

    task automatic do_instr(input logic [7:0] i, input logic [7:0] r0, input logic [7:0] r3);
        exp_t e;
        exp_t got;
        wait_fetch();
        checks++;
        if (pc !== exp_pc) begin
            errors++;
            $display("FAIL fetch_pc instr=%h: pc=%h required %h", i, pc, exp_pc);
        end
        sb.push_back(model(i, r0, r3, exp_pc));
        instr_in    = i;
        instr_valid = 1'b1;
        r0_in       = r0;
        r3_in       = r3;
        @(negedge clk);
        instr_valid = 1'b0;
        instr_in    = 8'hFF;
        e   = sb.pop_front();
        got = {src_a, src_b, dst, alu_op, wb_sel, imm_out, write_enable, e.next_pc};
        checks++;
        if (got !== e || instr_req !== 1'b0) begin
            errors++;
            $display("FAIL exec_decode instr=%h: got sa=%0d sb=%0d d=%0d op=%0d wb=%b imm=%h we=%b req=%b required sa=%0d sb=%0d d=%0d op=%0d wb=%b imm=%h we=%b req=0",
                     i, src_a, src_b, dst, alu_op, wb_sel, imm_out, write_enable, instr_req,
                     e.src_a, e.src_b, e.dst, e.alu_op, e.wb_sel, e.imm, e.we);
        end
        @(negedge clk);
        checks++;
        if (pc !== e.next_pc || write_enable !== 1'b0 || instr_req !== 1'b1) begin
            errors++;
            $display("FAIL next_pc instr=%h: pc=%h we=%b req=%b required pc=%h we=0 req=1",
                     i, pc, write_enable, instr_req, e.next_pc);
        end
        exp_pc = e.next_pc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({instr_req, pc, src_a, src_b, dst, alu_op, wb_sel, imm_out, write_enable} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b pc=%h sa=%0d sb=%0d d=%0d op=%0d wb=%b imm=%h we=%b required all 0",
                     instr_req, pc, src_a, src_b, dst, alu_op, wb_sel, imm_out, write_enable);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_req !== 1'b1 || pc !== 8'h00) begin
            errors++;
            $display("FAIL reset_to_fetch: req=%b pc=%h required req=1 pc=00", instr_req, pc);
        end
        exp_pc = 8'h00;
    endtask

    task automatic test_imm();     do_instr(8'h2A, 8'h00, 8'h00); endtask
    task automatic test_compute(); do_instr(8'h45, 8'h00, 8'h00); endtask
    task automatic test_copy();    do_instr(8'hBA, 8'h00, 8'h00); endtask

    task automatic test_cond();
        do_instr(8'hC2, 8'h40, 8'h80);
        do_instr(8'hC2, 8'h40, 8'h01);
    endtask

    task automatic test_wrap();
        do_instr(8'hC4, 8'hFF, 8'h00);
        do_instr(8'h2A, 8'h00, 8'h00);
    endtask

    task automatic test_stall();
        logic [7:0] held;
        wait_fetch();
        held        = pc;
        instr_in    = 8'h3C;
        instr_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (instr_req !== 1'b1 || pc !== held || write_enable !== 1'b0) begin
                errors++;
                $display("FAIL stall cycle %0d: req=%b pc=%h we=%b required req=1 pc=%h we=0",
                         k, instr_req, pc, write_enable, held);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++)
            do_instr(8'($urandom), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
    endtask

    task automatic test_reset_exec();
        wait_fetch();
        instr_in    = 8'h2A;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        reset       = 1'b1;
        #1;
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_exec_we: we=%b required 0", write_enable);
        end
        // instr_valid high alongside reset must lose to reset
        instr_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (pc !== 8'h00 || instr_req !== 1'b0 || write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_exec_after: pc=%h req=%b we=%b required pc=00 req=0 we=0",
                     pc, instr_req, write_enable);
        end
        @(negedge clk);
        checks++;
        if (instr_req !== 1'b0 || write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: req=%b we=%b required req=0 we=0", instr_req, write_enable);
        end
        instr_valid = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        exp_pc = 8'h00;
        do_instr(8'h45, 8'h00, 8'h00);
    endtask

    initial begin
        reset       = 1'b1;
        instr_in    = 8'h00;
        instr_valid = 1'b0;
        r0_in       = 8'h00;
        r3_in       = 8'h00;
        test_reset();
        test_imm();
        test_compute();
        test_copy();
        test_cond();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_reset_exec();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
